// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
// Shared definitions for the data-memory responder and its storage array.
//   state_t       : responder state encoding (IDLE=0, WAIT=1, RESP=2)
//   DEFAULT_DEPTH : default number of 32-bit words stored
//   WORD_OFFSET   : number of byte-offset bits below the word index
//   addr_err()    : flags a misaligned or out-of-range byte address
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH = 32;
    localparam int WORD_OFFSET   = 2;

    // A request is illegal when it is not word aligned or when its word
    // index falls past the end of the array.
    function automatic logic addr_err(input logic [31:0] addr, input int depth);
        logic [31:0] wordIdx;
        wordIdx = addr >> WORD_OFFSET;
        return (addr[WORD_OFFSET-1:0] != '0) || (wordIdx >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// DEPTH x 32 word storage with synchronous write and registered read.
// Contents are zero at time zero and are never cleared by reset.
//   i_clk   : clock
//   i_we    : write enable (pulsed only when an access commits)
//   i_re    : read enable, loads o_rdata from the addressed word
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : registered read data, holds between reads
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 5
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH] = '{default: '0};
    logic [31:0] r_rdata;

    // Write and read share one port; the responder never asserts both
    // enables on the same edge, so there is no read-during-write case.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Single-outstanding-request data memory responder with valid/ready
// handshakes on the request and response sides.
// Optional feature macro: DMEM_WAIT_EN adds a WAIT state that stretches
// each access by WAIT_CYCLES cycles; without it a response follows one
// cycle after acceptance and WAIT_CYCLES is only range-checked.
//   clk       : clock
//   reset     : asynchronous active-high reset
//   req_valid : request present          req_ready : accepting (IDLE only)
//   req_we    : 1 = store, 0 = load      req_addr  : byte address
//   req_wdata : store data
//   rsp_valid : response present         rsp_ready : requester takes response
//   rsp_rdata : load data (0 for stores, errors and outside RESP)
//   rsp_err   : misaligned or out-of-range request
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("dmem_responder: WAIT_CYCLES must be in 1..15");
    end

    state_t      r_state;
    logic        r_err;
    logic        r_rdOk;

    logic        w_accept;
    logic        w_commit;
    logic        w_cmtWe;
    logic [31:0] w_cmtAddr;
    logic [31:0] w_cmtWdata;
    logic        w_cmtErr;
    logic        w_memWe;
    logic        w_memRe;
    logic [31:0] w_memRdata;

    assign w_accept = req_valid && (r_state == IDLE);

`ifdef DMEM_WAIT_EN
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    // The access commits from the captured request when the countdown
    // has expired, so later activity on req_* cannot disturb it.
    assign w_commit   = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_cmtWe    = r_we;
    assign w_cmtAddr  = r_addr;
    assign w_cmtWdata = r_wdata;
`else
    // Acceptance and commit share one edge, so the live request is
    // the captured request.
    assign w_commit   = w_accept;
    assign w_cmtWe    = req_we;
    assign w_cmtAddr  = req_addr;
    assign w_cmtWdata = req_wdata;
`endif

    assign w_cmtErr = addr_err(w_cmtAddr, DEPTH);
    assign w_memWe  = w_commit && w_cmtWe && !w_cmtErr;
    assign w_memRe  = w_commit && !w_cmtWe && !w_cmtErr;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_memWe),
        .i_re    (w_memRe),
        .i_addr  (w_cmtAddr[AW+WORD_OFFSET-1:WORD_OFFSET]),
        .i_wdata (w_cmtWdata),
        .o_rdata (w_memRdata)
    );

    // Request/response sequencing. r_err and r_rdOk are only set on the
    // edge entering RESP and cleared on leaving it, which keeps the
    // response outputs at zero everywhere else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_rdOk  <= 1'b0;
`ifdef DMEM_WAIT_EN
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
`ifdef DMEM_WAIT_EN
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= 4'(WAIT_CYCLES - 1);
                        r_state <= WAIT;
`else
                        r_err   <= w_cmtErr;
                        r_rdOk  <= !w_cmtWe && !w_cmtErr;
                        r_state <= RESP;
`endif
                    end
                end
`ifdef DMEM_WAIT_EN
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_err   <= w_cmtErr;
                        r_rdOk  <= !w_cmtWe && !w_cmtErr;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        r_err   <= 1'b0;
                        r_rdOk  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_err   = r_err;
    assign rsp_rdata = r_rdOk ? w_memRdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed bench for dmem_responder (DEPTH=32, WAIT_CYCLES=2). Works in
// either build; expected latency follows DMEM_WAIT_EN.
module tb_dmem_responder;

    localparam int DEPTH       = 32;
    localparam int WAIT_CYCLES = 2;
`ifdef DMEM_WAIT_EN
    localparam int LAT = WAIT_CYCLES + 1;
`else
    localparam int LAT = 1;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int nChecks = 0;
    int nFails  = 0;

    dmem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
    endtask

    // One full transaction: accept, scramble req_* while it is in flight,
    // wait (bounded) for the response, check it, then hand it back.
    task automatic transact(input string tag, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] expRdata, input logic expErr);
        int cycles;
        applyStimulus(we, addr, wdata);
        checkOutput({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'hFFFF_FFFE;
        req_wdata = 32'hA5A5_A5A5;
        cycles = 1;
        while (!rsp_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        checkOutput({tag, " latency"}, 32'(cycles), 32'(LAT));
        checkOutput({tag, " rsp_err"}, {31'b0, rsp_err}, {31'b0, expErr});
        checkOutput({tag, " rsp_rdata"}, rsp_rdata, expRdata);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput({tag, " idle rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        checkOutput({tag, " idle rsp_rdata"}, rsp_rdata, 32'd0);
    endtask

    initial begin
        int cycles;
        $display("[TB] dmem_responder directed test, latency %0d", LAT);

        // Reset values while reset is held
        #2;
        checkOutput("reset req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset rsp_err", {31'b0, rsp_err}, 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Memory starts at zero; store then load back
        transact("ld44 init", 1'b0, 32'h44, 32'h0, 32'h0, 1'b0);
        transact("st44", 1'b1, 32'h44, 32'h0000_0007, 32'h0, 1'b0);
        transact("ld44", 1'b0, 32'h44, 32'h0, 32'h0000_0007, 1'b0);
        transact("st50", 1'b1, 32'h50, 32'h0000_000C, 32'h0, 1'b0);
        transact("ld50", 1'b0, 32'h50, 32'h0, 32'h0000_000C, 1'b0);

        // Last legal word, and an out-of-range store that would alias to
        // word 0 if the index were merely truncated
        transact("st7c", 1'b1, 32'h7C, 32'h1234_5678, 32'h0, 1'b0);
        transact("ld7c", 1'b0, 32'h7C, 32'h0, 32'h1234_5678, 1'b0);
        transact("ld46 misaligned", 1'b0, 32'h46, 32'h0, 32'h0, 1'b1);
        transact("st80 range", 1'b1, 32'h80, 32'hDEAD_BEEF, 32'h0, 1'b1);
        transact("st42 misaligned", 1'b1, 32'h42, 32'hCAFE_F00D, 32'h0, 1'b1);
        transact("ld00 untouched", 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
        transact("ld40 untouched", 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
        transact("ld44 untouched", 1'b0, 32'h44, 32'h0, 32'h0000_0007, 1'b0);

        // Back-pressure: response held while a new request is pending
        applyStimulus(1'b0, 32'h44, 32'h0);
        tick();
        req_addr = 32'h50;
        cycles = 1;
        while (!rsp_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        checkOutput("stall latency", 32'(cycles), 32'(LAT));
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall rsp_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("stall rsp_rdata", rsp_rdata, 32'h0000_0007);
            checkOutput("stall rsp_err", {31'b0, rsp_err}, 32'd0);
            checkOutput("stall req_ready", {31'b0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checkOutput("release req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("release rsp_valid", {31'b0, rsp_valid}, 32'd0);
        tick();
        checkOutput("no second accept", {31'b0, rsp_valid}, 32'd0);

        // Asynchronous reset during an access
`ifdef DMEM_WAIT_EN
        applyStimulus(1'b1, 32'h54, 32'h0000_0001);
        tick();
        req_valid = 1'b0;
        checkOutput("abort in WAIT", {31'b0, req_ready}, 32'd0);
`else
        applyStimulus(1'b0, 32'h44, 32'h0);
        tick();
        req_valid = 1'b0;
        checkOutput("abort in RESP", {31'b0, rsp_valid}, 32'd1);
`endif
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("async reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("async reset rsp_err", {31'b0, rsp_err}, 32'd0);
        checkOutput("async reset rsp_rdata", rsp_rdata, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        transact("ld54 after abort", 1'b0, 32'h54, 32'h0, 32'h0, 1'b0);
        transact("ld7c after reset", 1'b0, 32'h7C, 32'h0, 32'h1234_5678, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
